// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the dma_ctrl slice: default data/address width and FSM states.
// Optional abort support is selected with the DMA_ABORT_EN macro in dma_ctrl.sv.
package dma_ctrl_pkg;

    localparam int unsigned DMA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_addr_cnt.sv
// Loadable, incrementing address counter; wraps modulo 2^WIDTH with no carry flag.
module dma_addr_cnt
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DMA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel DMA sequencer copying xfer_len bytes from TX ROM to RX RAM, 2 cycles per byte.
// Define DMA_ABORT_EN to add the abort input (early termination from READ/WRITE).
module dma_ctrl
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DMA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src_addr,
    input  logic [WIDTH-1:0] dst_addr,
    input  logic [WIDTH-1:0] xfer_len,
    input  logic [WIDTH-1:0] data_tx_out,
`ifdef DMA_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] tx_mem_addr,
    output logic [WIDTH-1:0] rx_mem_addr,
    output logic [WIDTH-1:0] data_rx_in,
    output logic             mem_wr_en,
    output logic             busy,
    output logic             done
);

    dma_state_e       state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] tx_hold_q, tx_hold_d;
    logic [WIDTH-1:0] rx_hold_q, rx_hold_d;
    logic [WIDTH-1:0] src_cur, dst_cur;
    logic             accept;
    logic             abort_w;

`ifdef DMA_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && start;

    dma_addr_cnt #(.WIDTH(WIDTH)) u_src_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .inc_i      (state_q == ST_WRITE),
        .load_val_i (src_addr),
        .cnt_o      (src_cur)
    );

    dma_addr_cnt #(.WIDTH(WIDTH)) u_dst_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept),
        .inc_i      (state_q == ST_WRITE),
        .load_val_i (dst_addr),
        .cnt_o      (dst_cur)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = (xfer_len == '0) ? ST_DONE : ST_READ;
            ST_READ:  state_d = abort_w ? ST_DONE : ST_WRITE;
            ST_WRITE: state_d = (abort_w || remaining_q == WIDTH'(1)) ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
        endcase
    end

    // Hold registers keep the bus addresses stable once the counters have advanced past them.
    always_comb begin
        remaining_d = remaining_q;
        data_d      = data_q;
        tx_hold_d   = tx_hold_q;
        rx_hold_d   = rx_hold_q;
        if (accept) begin
            remaining_d = xfer_len;
        end
        if (state_q == ST_READ) begin
            data_d    = data_tx_out;
            tx_hold_d = src_cur;
        end
        if (state_q == ST_WRITE) begin
            remaining_d = remaining_q - WIDTH'(1);
            rx_hold_d   = dst_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
            data_q      <= '0;
            tx_hold_q   <= '0;
            rx_hold_q   <= '0;
        end else begin
            remaining_q <= remaining_d;
            data_q      <= data_d;
            tx_hold_q   <= tx_hold_d;
            rx_hold_q   <= rx_hold_d;
        end
    end

    always_comb begin
        busy        = (state_q == ST_READ) || (state_q == ST_WRITE);
        done        = (state_q == ST_DONE);
        mem_wr_en   = (state_q == ST_WRITE);
        tx_mem_addr = (state_q == ST_READ)  ? src_cur : tx_hold_q;
        rx_mem_addr = (state_q == ST_WRITE) ? dst_cur : rx_hold_q;
        data_rx_in  = data_q;
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: per-cycle bus expectations derived from the transfer schedule.
// Abort scenarios are exercised when DMA_ABORT_EN is defined.
module tb_dma_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] src_addr, dst_addr, xfer_len, data_tx_out;
    logic [7:0] tx_mem_addr, rx_mem_addr, data_rx_in;
    logic       mem_wr_en, busy, done;
`ifdef DMA_ABORT_EN
    logic       abort;
`endif

    logic [7:0] rom     [256];
    logic [7:0] ram     [256];
    logic [7:0] exp_ram [256];
    logic [7:0] exp_tx_hold, exp_rx_hold;
    int         n_total = 0;
    int         n_bad   = 0;
    int         wr_cnt  = 0;

    always #5 clk = ~clk;

    assign data_tx_out = rom[tx_mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            ram[rx_mem_addr] <= data_rx_in;
            wr_cnt <= wr_cnt + 1;
        end
    end

    dma_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .xfer_len    (xfer_len),
        .data_tx_out (data_tx_out),
`ifdef DMA_ABORT_EN
        .abort       (abort),
`endif
        .tx_mem_addr (tx_mem_addr),
        .rx_mem_addr (rx_mem_addr),
        .data_rx_in  (data_rx_in),
        .mem_wr_en   (mem_wr_en),
        .busy        (busy),
        .done        (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; start is raised in the current cycle (cycle 0).
    // rcyc/acyc: cycle in which rst/abort is raised (0 = never); inj: stray start cycle.
    task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input int len,
                            input int inj, input int rcyc, input int acyc);
        int e, last, nwr, wr0;
        logic [7:0] a, v;
        string t;
        if (len == 0)                        e = 1;
        else if (acyc > 0 && acyc <= 2*len)  e = acyc + 1;
        else                                 e = 2*len + 1;
        last = (rcyc > 0) ? rcyc + 2 : e + 1;
        nwr  = 0;
        wr0  = wr_cnt;
        start = 1'b1; src_addr = s; dst_addr = d; xfer_len = 8'(len);
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            t = $sformatf("s%0h d%0h n%0d c%0d", s, d, len, c);
            if (rcyc > 0 && c > rcyc) begin
                check_eq({t, " rst_busy"}, busy, 0);
                check_eq({t, " rst_done"}, done, 0);
                check_eq({t, " rst_wr"},   mem_wr_en, 0);
                check_eq({t, " rst_tx"},   tx_mem_addr, 0);
                check_eq({t, " rst_rx"},   rx_mem_addr, 0);
                check_eq({t, " rst_data"}, data_rx_in, 0);
                exp_tx_hold = 8'h00;
                exp_rx_hold = 8'h00;
            end else if (c < e) begin
                check_eq({t, " busy"}, busy, 1);
                check_eq({t, " done"}, done, 0);
                if (c % 2 == 0) begin
                    a = d + 8'(c/2 - 1);
                    v = rom[8'(s + 8'(c/2 - 1))];
                    check_eq({t, " wr"},   mem_wr_en, 1);
                    check_eq({t, " rx"},   rx_mem_addr, a);
                    check_eq({t, " data"}, data_rx_in, v);
                    check_eq({t, " tx"},   tx_mem_addr, exp_tx_hold);
                    exp_rx_hold = a;
                    exp_ram[a]  = v;
                    nwr++;
                end else begin
                    a = s + 8'((c - 1)/2);
                    check_eq({t, " wr"}, mem_wr_en, 0);
                    check_eq({t, " tx"}, tx_mem_addr, a);
                    check_eq({t, " rx"}, rx_mem_addr, exp_rx_hold);
                    exp_tx_hold = a;
                end
            end else begin
                check_eq({t, " done"}, done, (c == e));
                check_eq({t, " busy"}, busy, 0);
                check_eq({t, " wr"},   mem_wr_en, 0);
                check_eq({t, " tx"},   tx_mem_addr, exp_tx_hold);
                check_eq({t, " rx"},   rx_mem_addr, exp_rx_hold);
            end
            start = (c == inj);
            if (c == inj) begin
                src_addr = 8'($urandom); dst_addr = 8'($urandom); xfer_len = 8'($urandom_range(1, 255));
            end
`ifdef DMA_ABORT_EN
            abort = (c == acyc);
`endif
            rst = (rcyc > 0 && c >= rcyc && c < last);
        end
        check_eq($sformatf("s%0h d%0h n%0d wrcount", s, d, len), wr_cnt - wr0, nwr);
    endtask

    initial begin
        int len, mode, diffs;
        logic [7:0] s, d;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($urandom);
            ram[i] = 8'h00;
            exp_ram[i] = 8'h00;
        end
        exp_tx_hold = 8'h00;
        exp_rx_hold = 8'h00;
        rst = 1'b1; start = 1'b0; src_addr = 8'h00; dst_addr = 8'h00; xfer_len = 8'h00;
`ifdef DMA_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("reset busy", busy, 0);
        check_eq("reset done", done, 0);
        check_eq("reset wr",   mem_wr_en, 0);
        check_eq("reset tx",   tx_mem_addr, 0);
        check_eq("reset rx",   rx_mem_addr, 0);
        check_eq("reset data", data_rx_in, 0);
        rst = 1'b0;

        run_xfer(8'h10, 8'h40, 4, 0, 0, 0);
        run_xfer(8'h20, 8'h60, 0, 0, 0, 0);
        run_xfer(8'hFE, 8'hFF, 3, 0, 0, 0);
        run_xfer(8'h30, 8'hA0, 4, 3, 0, 0);
        run_xfer(8'h50, 8'hB0, 2, 0, 0, 0);
        run_xfer(8'h70, 8'hC0, 8, 0, 5, 0);
        run_xfer(8'h08, 8'hD0, 3, 0, 0, 0);
`ifdef DMA_ABORT_EN
        run_xfer(8'h00, 8'h80, 8, 0, 0, 3);
        run_xfer(8'h40, 8'h90, 5, 0, 0, 6);
`endif

        for (int k = 0; k < 30; k++) begin
            s    = 8'($urandom);
            d    = 8'($urandom);
            len  = $urandom_range(0, 12);
            mode = (len == 0) ? 0 : $urandom_range(0, 3);
            case (mode)
                1: run_xfer(s, d, len, $urandom_range(1, 2*len + 1), 0, 0);
                2: run_xfer(s, d, len, 0, $urandom_range(1, 2*len), 0);
`ifdef DMA_ABORT_EN
                3: run_xfer(s, d, len, 0, 0, $urandom_range(1, 2*len));
`endif
                default: run_xfer(s, d, len, 0, 0, 0);
            endcase
        end

        repeat (2) @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 256; i++) begin
            if (ram[i] !== exp_ram[i]) diffs++;
        end
        check_eq("ram contents", diffs, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
